// File: rtl/idu_issue.sv
// RV32 decode/issue stage: one-deep output register between fetch and the ALU.
// Optional IDU_PERF_CNT_EN adds perf_issued/perf_stall counters and ports.
module idu_issue (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] inst,
    input  logic [31:0] pc,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  rd,
    output logic        rd_wen,
    output logic        is_ebreak,
    output logic        illegal
`ifdef IDU_PERF_CNT_EN
    ,
    output logic [31:0] perf_issued,
    output logic [31:0] perf_stall
`endif
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned REGW = 5;
    localparam int unsigned OPW  = 4;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [XLEN-1:0] EBREAK_WORD = 32'h0010_0073;

    localparam logic [OPW-1:0] OP_ADD  = 4'b0000;
    localparam logic [OPW-1:0] OP_SUB  = 4'b0001;
    localparam logic [OPW-1:0] OP_AND  = 4'b0010;
    localparam logic [OPW-1:0] OP_OR   = 4'b0011;
    localparam logic [OPW-1:0] OP_XOR  = 4'b0100;
    localparam logic [OPW-1:0] OP_SLT  = 4'b0101;
    localparam logic [OPW-1:0] OP_SLTU = 4'b1101;

    typedef struct packed {
        logic [OPW-1:0]  alu_op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [REGW-1:0] rd;
        logic            rd_wen;
        logic            is_ebreak;
        logic            illegal;
    } issue_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state_q, state_d;
    issue_t payload_q, payload_d;
    issue_t dec;
    logic   alu_legal;
    logic   load;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [REGW-1:0] rd_field;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;

    assign opcode   = inst[6:0];
    assign funct3   = inst[14:12];
    assign funct7   = inst[31:25];
    assign rd_field = inst[11:7];
    assign imm_i    = {{20{inst[31]}}, inst[31:20]};
    assign imm_u    = {inst[31:12], 12'b0};

    assign rs1_addr = inst[19:15];
    assign rs2_addr = inst[24:20];

    // Instruction decode; anything not recognised collapses to a zero-operand ADD.
    always_comb begin
        dec       = '0;
        alu_legal = 1'b0;
        unique case (opcode)
            OPC_OP: begin
                dec.a     = rs1_data;
                dec.b     = rs2_data;
                alu_legal = (funct7 == F7_BASE);
                unique case (funct3)
                    3'b000: begin
                        if (funct7 == F7_ALT) begin
                            dec.alu_op = OP_SUB;
                            alu_legal  = 1'b1;
                        end else begin
                            dec.alu_op = OP_ADD;
                        end
                    end
                    3'b010:  dec.alu_op = OP_SLT;
                    3'b011:  dec.alu_op = OP_SLTU;
                    3'b100:  dec.alu_op = OP_XOR;
                    3'b110:  dec.alu_op = OP_OR;
                    3'b111:  dec.alu_op = OP_AND;
                    default: alu_legal  = 1'b0;
                endcase
            end
            OPC_OPIMM: begin
                dec.a     = rs1_data;
                dec.b     = imm_i;
                alu_legal = 1'b1;
                unique case (funct3)
                    3'b000:  dec.alu_op = OP_ADD;
                    3'b010:  dec.alu_op = OP_SLT;
                    3'b011:  dec.alu_op = OP_SLTU;
                    3'b100:  dec.alu_op = OP_XOR;
                    3'b110:  dec.alu_op = OP_OR;
                    3'b111:  dec.alu_op = OP_AND;
                    default: alu_legal  = 1'b0;
                endcase
            end
            OPC_LUI: begin
                dec.b     = imm_u;
                alu_legal = 1'b1;
            end
            OPC_AUIPC: begin
                dec.a     = pc;
                dec.b     = imm_u;
                alu_legal = 1'b1;
            end
            default: alu_legal = 1'b0;
        endcase

        if (alu_legal) begin
            dec.rd     = rd_field;
            dec.rd_wen = (rd_field != REGW'(0));
        end else begin
            dec           = '0;
            dec.is_ebreak = (inst == EBREAK_WORD);
            dec.illegal   = (inst != EBREAK_WORD);
        end
    end

    // Handshake FSM: ready whenever the output slot is empty or draining.
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        in_ready = (state_q == EMPTY) || out_ready;
        unique case (state_q)
            EMPTY: begin
                if (in_valid) begin
                    state_d = FULL;
                    load    = 1'b1;
                end
            end
            FULL: begin
                if (out_ready) begin
                    load    = in_valid;
                    state_d = in_valid ? FULL : EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
        payload_d = load ? dec : payload_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            payload_q <= '0;
        end else begin
            state_q   <= state_d;
            payload_q <= payload_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign alu_op    = payload_q.alu_op;
    assign alu_a     = payload_q.a;
    assign alu_b     = payload_q.b;
    assign rd        = payload_q.rd;
    assign rd_wen    = payload_q.rd_wen;
    assign is_ebreak = payload_q.is_ebreak;
    assign illegal   = payload_q.illegal;

`ifdef IDU_PERF_CNT_EN
    logic [XLEN-1:0] perf_issued_q;
    logic [XLEN-1:0] perf_stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued_q <= '0;
            perf_stall_q  <= '0;
        end else if (out_valid) begin
            if (out_ready) begin
                perf_issued_q <= perf_issued_q + XLEN'(1);
            end else begin
                perf_stall_q  <= perf_stall_q + XLEN'(1);
            end
        end
    end

    assign perf_issued = perf_issued_q;
    assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_idu_issue.sv
// Self-checking bench for idu_issue: directed scenarios plus a randomized run
// against a mnemonic-level reference decoder and a one-slot handshake model.
module tb_idu_issue;

    logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] inst, pc, rs1_data, rs2_data, alu_a, alu_b;
    logic [4:0]  rs1_addr, rs2_addr, rd;
    logic [3:0]  alu_op;
    logic        rd_wen, is_ebreak, illegal;
`ifdef IDU_PERF_CNT_EN
    logic [31:0] perf_issued, perf_stall;
`endif

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        wen;
        logic        ebk;
        logic        ill;
    } payload_t;

    typedef enum int {
        M_ILL, M_EBREAK, M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_SLT, M_SLTU,
        M_ADDI, M_ANDI, M_ORI, M_XORI, M_SLTI, M_SLTIU, M_LUI, M_AUIPC
    } mn_t;

    payload_t obs;
    assign obs = {alu_op, alu_a, alu_b, rd, rd_wen, is_ebreak, illegal};

    idu_issue dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .inst(inst), .pc(pc),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .rd(rd), .rd_wen(rd_wen), .is_ebreak(is_ebreak), .illegal(illegal)
`ifdef IDU_PERF_CNT_EN
        , .perf_issued(perf_issued), .perf_stall(perf_stall)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic mn_t classify(input logic [31:0] w);
        logic [6:0] f7;
        logic [2:0] f3;
        logic [6:0] opc;
        mn_t m;
        f7  = w[31:25];
        f3  = w[14:12];
        opc = w[6:0];
        m   = M_ILL;
        if (w == 32'h0010_0073) m = M_EBREAK;
        else if (opc == 7'h33 && f7 == 7'h20 && f3 == 3'd0) m = M_SUB;
        else if (opc == 7'h33 && f7 == 7'h00) begin
            case (f3)
                3'd0: m = M_ADD;  3'd2: m = M_SLT; 3'd3: m = M_SLTU;
                3'd4: m = M_XOR;  3'd6: m = M_OR;  3'd7: m = M_AND;
                default: m = M_ILL;
            endcase
        end else if (opc == 7'h13) begin
            case (f3)
                3'd0: m = M_ADDI; 3'd2: m = M_SLTI; 3'd3: m = M_SLTIU;
                3'd4: m = M_XORI; 3'd6: m = M_ORI;  3'd7: m = M_ANDI;
                default: m = M_ILL;
            endcase
        end else if (opc == 7'h37) m = M_LUI;
        else if (opc == 7'h17) m = M_AUIPC;
        return m;
    endfunction

    // Expected issue payload; chk_rd is 0 where the destination field is unspecified.
    function automatic payload_t ref_decode(input logic [31:0] w, input logic [31:0] pcv,
                                            input logic [31:0] r1, input logic [31:0] r2,
                                            output bit chk_rd);
        payload_t e;
        mn_t m;
        logic [31:0] simm, uimm;
        simm = 32'($signed(w[31:20]));
        uimm = {w[31:12], 12'h000};
        m = classify(w);
        e = '0;
        chk_rd = 1'b1;
        case (m)
            M_ADD:   begin e.op = 4'd0;  e.a = r1; e.b = r2; end
            M_SUB:   begin e.op = 4'd1;  e.a = r1; e.b = r2; end
            M_AND:   begin e.op = 4'd2;  e.a = r1; e.b = r2; end
            M_OR:    begin e.op = 4'd3;  e.a = r1; e.b = r2; end
            M_XOR:   begin e.op = 4'd4;  e.a = r1; e.b = r2; end
            M_SLT:   begin e.op = 4'd5;  e.a = r1; e.b = r2; end
            M_SLTU:  begin e.op = 4'd13; e.a = r1; e.b = r2; end
            M_ADDI:  begin e.op = 4'd0;  e.a = r1; e.b = simm; end
            M_ANDI:  begin e.op = 4'd2;  e.a = r1; e.b = simm; end
            M_ORI:   begin e.op = 4'd3;  e.a = r1; e.b = simm; end
            M_XORI:  begin e.op = 4'd4;  e.a = r1; e.b = simm; end
            M_SLTI:  begin e.op = 4'd5;  e.a = r1; e.b = simm; end
            M_SLTIU: begin e.op = 4'd13; e.a = r1; e.b = simm; end
            M_LUI:   begin e.op = 4'd0;  e.a = 32'd0; e.b = uimm; end
            M_AUIPC: begin e.op = 4'd0;  e.a = pcv;   e.b = uimm; end
            default: ;
        endcase
        if (m == M_EBREAK) begin
            e.ebk = 1'b1;
            chk_rd = 1'b0;
        end else if (m == M_ILL) begin
            e.ill = 1'b1;
            chk_rd = 1'b0;
        end else begin
            e.rd  = w[11:7];
            e.wen = (w[11:7] != 5'd0);
        end
        return e;
    endfunction

    function automatic logic [31:0] gen_inst();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 6))
            0: begin
                r[6:0] = 7'h33;
                if ($urandom_range(0, 2) == 0) r[31:25] = 7'h20;
                else if ($urandom_range(0, 4) != 0) r[31:25] = 7'h00;
            end
            1: r[6:0] = 7'h13;
            2: r[6:0] = 7'h37;
            3: r[6:0] = 7'h17;
            4: r = 32'h0010_0073;
            default: ;
        endcase
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        inst = 32'h0050_0093; pc = 32'h0; rs1_data = 32'h0; rs2_data = 32'h0;
        #3;
        n_cmp++;
        if (out_valid !== 1'b0 || obs !== '0) begin
            n_err++; $display("FAIL reset_outputs: valid=%b payload=%h want 0", out_valid, obs);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || obs !== '0) begin
            n_err++; $display("FAIL post_reset_idle: valid=%b payload=%h want 0", out_valid, obs);
        end
    endtask

    task automatic test_addi();
        @(negedge clk);
        inst = 32'h0050_0093; rs1_data = 32'd0; rs2_data = 32'hDEAD_BEEF; pc = 32'h100;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        n_cmp++;
        if (rs1_addr !== 5'd0 || rs2_addr !== 5'd5) begin
            n_err++; $display("FAIL addi_rf_addr: got %0d/%0d want 0/5", rs1_addr, rs2_addr);
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || obs !== {4'd0, 32'd0, 32'd5, 5'd1, 1'b1, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL addi_issue: valid=%b payload=%h", out_valid, obs);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        inst = 32'h4020_81B3; rs1_data = 32'd10; rs2_data = 32'd3;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || obs !== {4'd1, 32'd10, 32'd3, 5'd3, 1'b1, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL b2b_sub: valid=%b payload=%h", out_valid, obs);
        end
        inst = 32'hFFF3_3293; rs1_data = 32'h7; rs2_data = 32'h0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL b2b_in_ready: got %b want 1", in_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || obs !== {4'd13, 32'h7, 32'hFFFF_FFFF, 5'd5, 1'b1, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL b2b_sltiu: valid=%b payload=%h", out_valid, obs);
        end
        inst = 32'h0010_0013; rs1_data = 32'h0;
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || rd_wen !== 1'b0 || alu_b !== 32'd1) begin
            n_err++; $display("FAIL b2b_rd0: valid=%b rd_wen=%b b=%h want 1/0/1", out_valid, rd_wen, alu_b);
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL b2b_empty: got %b want 0", out_valid);
        end
    endtask

    task automatic test_stall();
        do_reset();
        @(negedge clk);
        inst = 32'h1234_53B7; rs1_data = 32'h55; rs2_data = 32'h66;
        in_valid = 1'b1; out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            inst = 32'h0050_0093;
            #1;
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                obs !== {4'd0, 32'd0, 32'h1234_5000, 5'd7, 1'b1, 1'b0, 1'b0}) begin
                n_err++; $display("FAIL stall_hold[%0d]: valid=%b in_ready=%b payload=%h", c, out_valid, in_ready, obs);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || alu_b !== 32'h1234_5000) begin
            n_err++; $display("FAIL stall_end: valid=%b b=%h", out_valid, alu_b);
        end
`ifdef IDU_PERF_CNT_EN
        n_cmp++;
        if (perf_stall !== 32'd3 || perf_issued !== 32'd0) begin
            n_err++; $display("FAIL perf_stall: got %0d/%0d want 3/0", perf_stall, perf_issued);
        end
`endif
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || alu_b !== 32'h1234_5000 || rd !== 5'd7) begin
            n_err++; $display("FAIL stall_release: valid=%b b=%h rd=%0d", out_valid, alu_b, rd);
        end
`ifdef IDU_PERF_CNT_EN
        n_cmp++;
        if (perf_issued !== 32'd1 || perf_stall !== 32'd3) begin
            n_err++; $display("FAIL perf_issued: got %0d/%0d want 1/3", perf_issued, perf_stall);
        end
`endif
    endtask

    task automatic test_illegal_ebreak();
        @(negedge clk);
        inst = 32'h0000_0000; rs1_data = 32'h1111; rs2_data = 32'h2222;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || illegal !== 1'b1 || is_ebreak !== 1'b0 || rd_wen !== 1'b0 ||
            alu_op !== 4'd0 || alu_a !== 32'd0 || alu_b !== 32'd0) begin
            n_err++; $display("FAIL illegal_zero: valid=%b payload=%h", out_valid, obs);
        end
        inst = 32'h0010_0073;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || illegal !== 1'b0 || is_ebreak !== 1'b1 || rd_wen !== 1'b0 ||
            alu_op !== 4'd0 || alu_a !== 32'd0 || alu_b !== 32'd0) begin
            n_err++; $display("FAIL ebreak: valid=%b payload=%h", out_valid, obs);
        end
        inst = 32'h0010_1093;
        @(negedge clk);
        n_cmp++;
        if (illegal !== 1'b1 || rd_wen !== 1'b0 || alu_a !== 32'd0) begin
            n_err++; $display("FAIL illegal_slli: payload=%h", obs);
        end
        drain();
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        inst = 32'h0050_0093; rs1_data = 32'd0; rs2_data = 32'd0;
        in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_err++; $display("FAIL areset_full: got %b want 1", out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || obs !== '0) begin
            n_err++; $display("FAIL areset_clear: valid=%b payload=%h want 0", out_valid, obs);
        end
`ifdef IDU_PERF_CNT_EN
        n_cmp++;
        if (perf_issued !== 32'd0 || perf_stall !== 32'd0) begin
            n_err++; $display("FAIL areset_perf: got %0d/%0d want 0/0", perf_issued, perf_stall);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL areset_release: in_ready=%b valid=%b want 1/0", in_ready, out_valid);
        end
        inst = 32'h4020_81B3; rs1_data = 32'd10; rs2_data = 32'd3;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || obs !== {4'd1, 32'd10, 32'd3, 5'd3, 1'b1, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL areset_first_issue: valid=%b payload=%h", out_valid, obs);
        end
        drain();
    endtask

    task automatic test_random();
        bit       exp_valid;
        payload_t exp_p;
        bit       exp_chk_rd;
        bit       nchk;
        payload_t nxt;
        int       exp_issued, exp_stall;
        logic [75:0] m_obs, m_exp;
        do_reset();
        exp_valid = 1'b0; exp_p = '0; exp_chk_rd = 1'b1;
        exp_issued = 0; exp_stall = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            m_obs = obs;
            m_exp = exp_p;
            if (!exp_chk_rd) begin
                m_obs[7:3] = 5'd0;
                m_exp[7:3] = 5'd0;
            end
            n_cmp++;
            if (out_valid !== exp_valid || m_obs !== m_exp) begin
                n_err++; $display("FAIL rand_out[%0d]: valid=%b payload=%h want valid=%b payload=%h",
                                  i, out_valid, obs, exp_valid, exp_p);
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            inst      = gen_inst();
            pc        = $urandom & 32'hFFFF_FFFC;
            rs1_data  = $urandom;
            rs2_data  = $urandom;
            #1;
            n_cmp++;
            if (in_ready !== (!exp_valid || out_ready) ||
                rs1_addr !== inst[19:15] || rs2_addr !== inst[24:20]) begin
                n_err++; $display("FAIL rand_comb[%0d]: in_ready=%b rs1=%0d rs2=%0d inst=%h",
                                  i, in_ready, rs1_addr, rs2_addr, inst);
            end
            if (exp_valid && out_ready) exp_issued++;
            if (exp_valid && !out_ready) exp_stall++;
            if (in_valid && (!exp_valid || out_ready)) begin
                nxt = ref_decode(inst, pc, rs1_data, rs2_data, nchk);
                exp_p = nxt;
                exp_chk_rd = nchk;
                exp_valid = 1'b1;
            end else if (out_ready) begin
                exp_valid = 1'b0;
            end
        end
        @(negedge clk);
`ifdef IDU_PERF_CNT_EN
        n_cmp++;
        if (perf_issued !== 32'(exp_issued) || perf_stall !== 32'(exp_stall)) begin
            n_err++; $display("FAIL rand_perf: got %0d/%0d want %0d/%0d",
                              perf_issued, perf_stall, exp_issued, exp_stall);
        end
`endif
        n_cmp++;
        if (out_valid !== exp_valid) begin
            n_err++; $display("FAIL rand_final_valid: got %b want %b", out_valid, exp_valid);
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_stall();
        test_illegal_ebreak();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
